// File: rtl/clk_ena_ctrl.sv
// Clock-enable controller paired with the external clock generator: HALT gates the core clocks,
// STOP also shuts down the oscillator, and a settle counter qualifies OSC_STABLE before restart.
module clk_ena_ctrl #(
  parameter int SETTLE_CYCLES = 16,
  parameter int CNT_W         = 5
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       HALT_REQ,
  input  logic       STOP_REQ,
  input  logic       INT_PENDING,
  input  logic       JOYPAD_WAKE,
  input  logic       OSC_STABLE,
  input  logic       SYNC_RESET,
  output logic       CLK_ENA,
  output logic       OSC_ENA,
  output logic       WAKE,
  output logic [2:0] STATE
);

  localparam logic [2:0] ST_RUN      = 3'd0;
  localparam logic [2:0] ST_HALT     = 3'd1;
  localparam logic [2:0] ST_STOP     = 3'd2;
  localparam logic [2:0] ST_OSC_WAIT = 3'd3;
  localparam logic [2:0] ST_RESUME   = 3'd4;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

  logic [2:0]       state_r;
  logic [2:0]       state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic             clk_ena_r;
  logic             osc_ena_r;
  logic             wake_r;
  logic             clk_ena_s;
  logic             osc_ena_s;
  logic             wake_s;

  // State, settle counter and decoded outputs; outputs are decoded from the next state
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_r   <= ST_RUN;
      cnt_r     <= CNT_ZERO;
      clk_ena_r <= 1'b1;
      osc_ena_r <= 1'b1;
      wake_r    <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      cnt_r     <= cnt_nxt_s;
      clk_ena_r <= clk_ena_s;
      osc_ena_r <= osc_ena_s;
      wake_r    <= wake_s;
    end
  end

  // Next-state and settle-counter logic
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = CNT_ZERO;
    if (SYNC_RESET) begin
      state_nxt_s = ST_RUN;
      cnt_nxt_s   = CNT_ZERO;
    end else begin
      case (state_r)
        ST_RUN: begin
          // A STOP with a joypad line already held is a NOP and also masks HALT.
          if (STOP_REQ) begin
            if (!JOYPAD_WAKE) begin
              state_nxt_s = ST_STOP;
            end else begin
              state_nxt_s = ST_RUN;
            end
          end else if (HALT_REQ) begin
            if (INT_PENDING) begin
              state_nxt_s = ST_RESUME;
            end else begin
              state_nxt_s = ST_HALT;
            end
          end else begin
            state_nxt_s = ST_RUN;
          end
        end
        ST_HALT: begin
          if (INT_PENDING) begin
            state_nxt_s = ST_RESUME;
          end else begin
            state_nxt_s = ST_HALT;
          end
        end
        ST_STOP: begin
          if (JOYPAD_WAKE) begin
            state_nxt_s = ST_OSC_WAIT;
          end else begin
            state_nxt_s = ST_STOP;
          end
        end
        ST_OSC_WAIT: begin
          if (!OSC_STABLE) begin
            state_nxt_s = ST_OSC_WAIT;
            cnt_nxt_s   = CNT_ZERO;
          end else if (cnt_r == CNT_LAST) begin
            state_nxt_s = ST_RESUME;
            cnt_nxt_s   = CNT_ZERO;
          end else if (cnt_r != CNT_MAX) begin
            state_nxt_s = ST_OSC_WAIT;
            cnt_nxt_s   = cnt_r + CNT_ONE;
          end else begin
            state_nxt_s = ST_OSC_WAIT;
            cnt_nxt_s   = cnt_r;
          end
        end
        ST_RESUME: begin
          state_nxt_s = ST_RUN;
        end
        default: begin
          // Unreachable encodings recover to RUN with clocks enabled.
          state_nxt_s = ST_RUN;
          cnt_nxt_s   = CNT_ZERO;
        end
      endcase
    end
  end

  // Output decode of the next state
  always_comb begin
    clk_ena_s = 1'b1;
    osc_ena_s = 1'b1;
    wake_s    = 1'b0;
    case (state_nxt_s)
      ST_RUN: begin
        clk_ena_s = 1'b1;
        osc_ena_s = 1'b1;
        wake_s    = 1'b0;
      end
      ST_HALT: begin
        clk_ena_s = 1'b0;
        osc_ena_s = 1'b1;
        wake_s    = 1'b0;
      end
      ST_STOP: begin
        clk_ena_s = 1'b0;
        osc_ena_s = 1'b0;
        wake_s    = 1'b0;
      end
      ST_OSC_WAIT: begin
        clk_ena_s = 1'b0;
        osc_ena_s = 1'b1;
        wake_s    = 1'b0;
      end
      ST_RESUME: begin
        clk_ena_s = 1'b1;
        osc_ena_s = 1'b1;
        wake_s    = 1'b1;
      end
      default: begin
        clk_ena_s = 1'b1;
        osc_ena_s = 1'b1;
        wake_s    = 1'b0;
      end
    endcase
  end

  assign CLK_ENA = clk_ena_r;
  assign OSC_ENA = osc_ena_r;
  assign WAKE    = wake_r;
  assign STATE   = state_r;

endmodule

// File: doc/clk_ena_ctrl.md
Name: clk_ena_ctrl

Overview:
- CPU-side counterpart of the external clock generator. It drives CLK_ENA and OSC_ENA into the generator and consumes OSC_STABLE and SYNC_RESET from it.
- Implements HALT (core clocks gated, oscillator running) and STOP (oscillator off), with interrupt/joypad wake-up and an oscillator settle counter.
- Runs on the free-running crystal clock, before OSC_ENA gating, so it keeps ticking in STOP.

Parameters:
SETTLE_CYCLES, 16, consecutive CLK cycles OSC_STABLE must be high before clocks restart after STOP; legal range 1..2^CNT_W-1
CNT_W, 5, settle counter width

Ports:
CLK  input  1  free-running crystal clock, all state on rising edge
RESET_N  input  1  asynchronous active-low reset
HALT_REQ  input  1  CPU decoded HALT, sampled in RUN only
STOP_REQ  input  1  CPU decoded STOP, sampled in RUN only
INT_PENDING  input  1  OR of enabled pending interrupts (IE & IF)
JOYPAD_WAKE  input  1  level, any joypad line asserted
OSC_STABLE  input  1  from clock generator
SYNC_RESET  input  1  from clock generator, synchronous clear
CLK_ENA  output  1  to clock generator, core phase clocks enabled
OSC_ENA  output  1  to clock generator, oscillator/phase splitter enabled
WAKE  output  1  one-cycle pulse, CPU resumes from HALT/STOP
STATE  output  3  debug: RUN=0 HALT=1 STOP=2 OSC_WAIT=3 RESUME=4

Behaviour:
- All outputs registered, decoded from the state register. The settle counter is CNT_W bits.
- RESET_N low, asynchronous: STATE=RUN, CLK_ENA=1, OSC_ENA=1, WAKE=0, counter=0. Takes effect immediately in any state, including mid-STOP (OSC_ENA returns to 1 without a settle wait).
- SYNC_RESET high at a clock edge: same values as reset, applied synchronously, overrides all transitions.
- Output decode per state:
  - RUN: CLK_ENA=1, OSC_ENA=1, WAKE=0
  - HALT: CLK_ENA=0, OSC_ENA=1
  - STOP: CLK_ENA=0, OSC_ENA=0
  - OSC_WAIT: CLK_ENA=0, OSC_ENA=1
  - RESUME: CLK_ENA=1, OSC_ENA=1, WAKE=1
- RUN transitions, priority order:
  - STOP_REQ=1 and JOYPAD_WAKE=0 -> STOP.
  - STOP_REQ=1 and JOYPAD_WAKE=1 -> stay RUN. STOP is a NOP; no WAKE pulse.
  - HALT_REQ=1 and INT_PENDING=0 -> HALT.
  - HALT_REQ=1 and INT_PENDING=1 -> RESUME (halt bypass: single WAKE pulse, CLK_ENA never drops).
  - STOP_REQ has priority over HALT_REQ when both are high.
- HALT: INT_PENDING=1 -> RESUME; otherwise hold. JOYPAD_WAKE is ignored unless it is also reflected in INT_PENDING.
- STOP: JOYPAD_WAKE=1 -> OSC_WAIT, counter cleared. INT_PENDING alone does not wake from STOP.
- OSC_WAIT:
  - OSC_STABLE=0 -> counter cleared, hold.
  - OSC_STABLE=1 and counter==SETTLE_CYCLES-1 -> RESUME.
  - Otherwise counter+1.
  - A dropout of OSC_STABLE restarts the count.
  - The counter saturates and never wraps.
  - JOYPAD_WAKE is ignored once in OSC_WAIT.
- RESUME -> RUN unconditionally after one cycle.
- HALT_REQ and STOP_REQ are ignored in every state except RUN.
- Latency, with the request sampled at edge N:
  - HALT/STOP entry: CLK_ENA=0 (and OSC_ENA=0 for STOP) after edge N.
  - HALT exit: STATE=RESUME, CLK_ENA=1, WAKE=1 after edge N; STATE=RUN after edge N+1.
  - STOP exit: OSC_ENA=1 after edge N (the JOYPAD_WAKE sample). With OSC_STABLE continuously 1 from edge N+1, RESUME follows after edge N+SETTLE_CYCLES.

Test Plan:
- Release RESET_N; HALT_REQ=1 for 1 cycle with INT_PENDING=0 -> STATE=1, CLK_ENA=0, OSC_ENA=1; assert INT_PENDING at edge N -> after N: CLK_ENA=1, WAKE=1, STATE=4; after N+1: STATE=0, WAKE=0.
- HALT_REQ=1 with INT_PENDING=1 -> CLK_ENA stays 1 throughout, WAKE high exactly one cycle, STATE 0->4->0.
- STOP_REQ=1, JOYPAD_WAKE=0 -> STATE=2, CLK_ENA=0, OSC_ENA=0. JOYPAD_WAKE=1 and OSC_STABLE=1 held -> OSC_ENA=1 next cycle; CLK_ENA=1 and WAKE=1 exactly 16 edges after JOYPAD_WAKE sampled (SETTLE_CYCLES=16).
- In OSC_WAIT, drop OSC_STABLE for 1 cycle after 10 stable cycles -> counter restarts; RESUME occurs 16 stable cycles after OSC_STABLE returns.
- HALT_REQ=1 and STOP_REQ=1 together, JOYPAD_WAKE=0 -> STATE=2. STOP_REQ=1 with JOYPAD_WAKE=1 -> STATE stays 0, WAKE stays 0.
- In STOP, pulse RESET_N low mid-cycle -> CLK_ENA=1, OSC_ENA=1 immediately (before next edge). Separately, SYNC_RESET=1 in HALT -> STATE=0, CLK_ENA=1 after next edge, no WAKE.
